// File: rtl/mem_browse_pkg.sv
// ============================================================================
// Module      : mem_browse_pkg
// Description : Shared types and constants for the memory browse controller.
//               Holds the FSM state encoding, bus widths and the default
//               debounce length.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_browse_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;
    localparam int NIB_W  = 4;

    // 10 ms of stable level at 50 MHz
    localparam int DEB_CYCLES_DEFAULT = 500000;

    typedef enum logic [2:0] {
        ST_START = 3'd0,
        ST_IDLE  = 3'd1,
        ST_WRITE = 3'd2,
        ST_READ  = 3'd3,
        ST_LATCH = 3'd4
    } state_e;

endpackage : mem_browse_pkg

`default_nettype wire

// File: rtl/btn_debounce.sv
// ============================================================================
// Module      : btn_debounce
// Description : Push-button conditioner. Two-flop synchronizer, stable-level
//               counter and rising-edge pulse generator.
//   clk      in   system clock
//   reset    in   synchronous, active-low reset (clears to "released")
//   btn_i    in   raw asynchronous bouncy button, active-high
//   pulse_o  out  one-cycle pulse on each accepted press
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_debounce #(
    parameter int DEB_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic pulse_o
);

    // Counter only has to reach DEB_CYCLES-1
    localparam int                 CNT_W    = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pulse_q, pulse_d;

    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        pulse_d = 1'b0;
        if (sync_q[1] != level_q) begin
            // Any return to the accepted level restarts the count, so only an
            // uninterrupted run of DEB_CYCLES new-level samples flips it.
            if (cnt_q == CNT_LAST) begin
                level_d = sync_q[1];
                pulse_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_q  <= 2'b00;
            level_q <= 1'b0;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], btn_i};
            level_q <= level_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse_o = pulse_q;

endmodule : btn_debounce

`default_nettype wire

// File: rtl/mem_browse_controller.sv
// ============================================================================
// Module      : mem_browse_controller
// Description : Steps through a 256x8 synchronous RAM with a debounced step
//               button and overwrites the shown word from switches with a
//               debounced write button. Address and data shown on the display
//               always come from the same completed read.
//   clk, reset            clock / synchronous active-low reset
//   btn_step, btn_write   raw buttons
//   sw_data               value to write
//   mem_rdata             RAM read data (valid RD_LAT cycles after mem_addr)
//   mem_addr/wdata/we     registered RAM control, mem_we is a 1-cycle pulse
//   ad_high..d_low        display nibbles (address, data)
//   busy                  high while the FSM is not in IDLE
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_browse_controller
    import mem_browse_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT,
    parameter int RD_LAT     = 1          // legal range 1..3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              btn_step,
    input  logic              btn_write,
    input  logic [DATA_W-1:0] sw_data,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic [NIB_W-1:0]  ad_high,
    output logic [NIB_W-1:0]  ad_low,
    output logic [NIB_W-1:0]  d_high,
    output logic [NIB_W-1:0]  d_low,
    output logic              busy
);

    localparam logic [1:0] WAIT_LAST = 2'(RD_LAT - 1);

    logic step_pulse;
    logic write_pulse;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_step (
        .clk     (clk),
        .reset   (reset),
        .btn_i   (btn_step),
        .pulse_o (step_pulse)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_write (
        .clk     (clk),
        .reset   (reset),
        .btn_i   (btn_write),
        .pulse_o (write_pulse)
    );

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic [1:0]        wait_q, wait_d;
    logic [ADDR_W-1:0] disp_addr_q, disp_addr_d;
    logic [DATA_W-1:0] disp_data_q, disp_data_d;
    logic              busy_q;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        we_d        = 1'b0;
        wait_d      = wait_q;
        disp_addr_d = disp_addr_q;
        disp_data_d = disp_data_q;

        unique case (state_q)
            ST_START: begin
                // Load address 0 so a valid word is on the display after reset
                addr_d  = '0;
                wait_d  = '0;
                state_d = ST_READ;
            end
            ST_IDLE: begin
                // Write has priority; a coincident step pulse is discarded
                if (write_pulse) begin
                    we_d    = 1'b1;
                    wdata_d = sw_data;
                    state_d = ST_WRITE;
                end else if (step_pulse) begin
                    addr_d  = addr_q + 1'b1;
                    wait_d  = '0;
                    state_d = ST_READ;
                end
            end
            ST_WRITE: begin
                // Re-read the same location so the display shows the new value
                wait_d  = '0;
                state_d = ST_READ;
            end
            ST_READ: begin
                if (wait_q == WAIT_LAST) begin
                    wait_d  = '0;
                    state_d = ST_LATCH;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            ST_LATCH: begin
                // Address and data are captured together in one edge
                disp_addr_d = addr_q;
                disp_data_d = mem_rdata;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_START;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_START;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            wait_q      <= '0;
            disp_addr_q <= '0;
            disp_data_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            wait_q      <= wait_d;
            disp_addr_q <= disp_addr_d;
            disp_data_q <= disp_data_d;
            // Registered so it tracks the state register exactly while still
            // reading 0 in the reset cycle
            busy_q      <= (state_d != ST_IDLE);
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_we    = we_q;
    assign ad_high   = disp_addr_q[ADDR_W-1 -: NIB_W];
    assign ad_low    = disp_addr_q[NIB_W-1:0];
    assign d_high    = disp_data_q[DATA_W-1 -: NIB_W];
    assign d_low     = disp_data_q[NIB_W-1:0];
    assign busy      = busy_q;

endmodule : mem_browse_controller

`default_nettype wire

// File: tb/tb_mem_browse_controller.sv
// ============================================================================
// Module      : tb_mem_browse_controller
// Description : Scoreboard bench for mem_browse_controller with a behavioural
//               256x8 synchronous RAM preloaded with mem[i] = i ^ 0xA5.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_browse_controller;
    import mem_browse_pkg::*;

    localparam int DEB    = 4;
    localparam int RD_LAT = 1;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       btn_step = 1'b0;
    logic       btn_write = 1'b0;
    logic [7:0] sw_data = 8'h00;
    logic [7:0] mem_rdata;
    logic [7:0] mem_addr, mem_wdata;
    logic       mem_we;
    logic [3:0] ad_high, ad_low, d_high, d_low;
    logic       busy;

    always #5 clk = ~clk;

    mem_browse_controller #(.DEB_CYCLES(DEB), .RD_LAT(RD_LAT)) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_step  (btn_step),
        .btn_write (btn_write),
        .sw_data   (sw_data),
        .mem_rdata (mem_rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .ad_high   (ad_high),
        .ad_low    (ad_low),
        .d_high    (d_high),
        .d_low     (d_low),
        .busy      (busy)
    );

    // External RAM, read-before-write, one cycle read latency
    logic [7:0] ram [256];
    initial for (int i = 0; i < 256; i++) ram[i] = 8'(i) ^ 8'hA5;
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    // Scoreboard
    typedef struct {
        logic [7:0] a;
        logic [7:0] d;
        int         blen;
    } disp_t;
    typedef struct {
        logic [7:0] a;
        logic [7:0] d;
    } wr_t;

    disp_t disp_q[$];
    wr_t   wr_q[$];
    int    n_chk = 0;
    int    n_fail = 0;

    logic [7:0] model [256];
    logic [7:0] addr_m;
    initial for (int i = 0; i < 256; i++) model[i] = 8'(i) ^ 8'hA5;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Monitor: a busy falling edge marks a completed display update, a high
    // mem_we marks a write; each is matched against the queued expectation.
    logic prev_busy = 1'b0;
    logic prev_we = 1'b0;
    int   busy_len = 0;
    always @(negedge clk) begin
        if (!reset) begin
            prev_busy = 1'b0;
            prev_we   = 1'b0;
            busy_len  = 0;
        end else begin
            if (busy) busy_len++;
            if (prev_busy && !busy) begin
                n_chk++;
                if (disp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL disp_unexpected: got %h%h/%h%h with no update expected",
                             ad_high, ad_low, d_high, d_low);
                end else begin
                    disp_t e;
                    e = disp_q.pop_front();
                    if ({ad_high, ad_low} !== e.a || {d_high, d_low} !== e.d || busy_len != e.blen) begin
                        n_fail++;
                        $display("FAIL disp: got %h%h/%h%h busy %0d expected %h/%h busy %0d",
                                 ad_high, ad_low, d_high, d_low, busy_len, e.a, e.d, e.blen);
                    end
                end
                busy_len = 0;
            end
            if (mem_we) begin
                n_chk++;
                if (prev_we) begin
                    n_fail++;
                    $display("FAIL we_width: mem_we high for 2+ cycles, expected 1");
                end else if (wr_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL wr_unexpected: write addr %h data %h", mem_addr, mem_wdata);
                end else begin
                    wr_t w;
                    w = wr_q.pop_front();
                    if (mem_addr !== w.a || mem_wdata !== w.d) begin
                        n_fail++;
                        $display("FAIL wr: got addr %h data %h expected addr %h data %h",
                                 mem_addr, mem_wdata, w.a, w.d);
                    end
                end
            end
            prev_busy = busy;
            prev_we   = mem_we;
        end
    end

    task automatic push_disp(input logic [7:0] a, input logic [7:0] d, input int blen);
        disp_t e;
        e.a = a; e.d = d; e.blen = blen;
        disp_q.push_back(e);
    endtask

    task automatic push_wr(input logic [7:0] a, input logic [7:0] d);
        wr_t w;
        w.a = a; w.d = d;
        wr_q.push_back(w);
        model[a] = d;
        push_disp(a, d, RD_LAT + 2);
    endtask

    task automatic step_press(input int hold);
        addr_m = addr_m + 8'd1;
        push_disp(addr_m, model[addr_m], RD_LAT + 1);
        btn_step = 1'b1;
        tick(hold);
        btn_step = 1'b0;
        tick(12);
    endtask

    task automatic write_press(input logic [7:0] val);
        sw_data = val;
        push_wr(addr_m, val);
        btn_write = 1'b1;
        tick(8);
        btn_write = 1'b0;
        tick(12);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        addr_m = 8'h00;

        // Reset state
        reset = 1'b0;
        tick(4);
        chk("rst_addr", 32'(mem_addr), 32'h00);
        chk("rst_we", 32'(mem_we), 32'h0);
        chk("rst_disp", 32'({ad_high, ad_low, d_high, d_low}), 32'h0000);
        chk("rst_busy", 32'(busy), 32'h0);

        // Auto-read of address 0 after release
        push_disp(8'h00, 8'hA5, RD_LAT + 1);
        reset = 1'b1;
        tick(3);
        chk("start_disp", 32'({ad_high, ad_low, d_high, d_low}), 32'h00A5);
        chk("start_busy", 32'(busy), 32'h0);
        tick(5);

        // Clean press held 10 cycles: exactly one increment
        step_press(10);
        chk("step_addr", 32'(mem_addr), 32'h01);

        // Bouncy press, then stable high
        addr_m = addr_m + 8'd1;
        push_disp(addr_m, model[addr_m], RD_LAT + 1);
        for (int i = 0; i < 5; i++) begin
            btn_step = 1'b1; tick(2);
            btn_step = 1'b0; tick(2);
        end
        btn_step = 1'b1;
        tick(10);
        btn_step = 1'b0;
        tick(12);
        chk("bounce_addr", 32'(mem_addr), 32'h02);

        // Write 0x3C at 0x05
        while (addr_m != 8'h05) step_press(8);
        write_press(8'h3C);
        chk("wr05_addr", 32'(mem_addr), 32'h05);

        // Step and write together at 0x10: write wins
        while (addr_m != 8'h10) step_press(8);
        sw_data = 8'h77;
        push_wr(8'h10, 8'h77);
        btn_step = 1'b1; btn_write = 1'b1;
        tick(8);
        btn_step = 1'b0; btn_write = 1'b0;
        tick(12);
        chk("both_addr", 32'(mem_addr), 32'h10);

        // Step pulse landing two cycles after the write pulse (FSM busy)
        sw_data = 8'h99;
        push_wr(8'h10, 8'h99);
        btn_write = 1'b1;
        tick(2);
        btn_step = 1'b1;
        tick(8);
        btn_step = 1'b0; btn_write = 1'b0;
        tick(14);
        chk("drop_addr", 32'(mem_addr), 32'h10);

        // Walk to 0xFF then wrap
        while (addr_m != 8'hFF) step_press(8);
        chk("ff_addr", 32'(mem_addr), 32'hFF);
        step_press(8);
        chk("wrap_addr", 32'(mem_addr), 32'h00);
        chk("wrap_disp", 32'({ad_high, ad_low, d_high, d_low}), 32'h00A5);

        // Reset while mem_we is high
        sw_data   = 8'h5A;
        btn_write = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            tick(1);
            if (mem_we) seen = 1'b1;
        end
        chk("rw_we_seen", 32'(seen), 32'h1);
        reset     = 1'b0;
        btn_write = 1'b0;
        tick(1);
        chk("rw_we", 32'(mem_we), 32'h0);
        chk("rw_disp", 32'({ad_high, ad_low, d_high, d_low}), 32'h0000);
        chk("rw_state", 32'(dut.state_q), 32'(ST_START));
        chk("rw_addr", 32'(mem_addr), 32'h00);
        tick(2);
        push_disp(8'h00, ram[0], RD_LAT + 1);
        reset = 1'b1;
        tick(12);

        chk("disp_q_empty", 32'(disp_q.size()), 32'd0);
        chk("wr_q_empty", 32'(wr_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_mem_browse_controller

`default_nettype wire
